// File: rtl/mips_defs.sv
// mips_defs: opcode/funct encodings, hazard timing constants and the stall predicate
package mips_defs;
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_SLTI   = 6'h0a;
  localparam logic [5:0] OP_SLTIU  = 6'h0b;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_XORI   = 6'h0e;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SW     = 6'h2b;
  localparam logic [5:0] FN_SLL    = 6'h00;
  localparam logic [5:0] FN_SRL    = 6'h02;
  localparam logic [5:0] FN_SRA    = 6'h03;
  localparam logic [5:0] FN_SLLV   = 6'h04;
  localparam logic [5:0] FN_SRLV   = 6'h06;
  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_JALR   = 6'h09;
  localparam logic [5:0] FN_MOVZ   = 6'h0a;
  localparam logic [5:0] FN_ADD    = 6'h20;
  localparam logic [5:0] FN_ADDU   = 6'h21;
  localparam logic [5:0] FN_SUB    = 6'h22;
  localparam logic [5:0] FN_SUBU   = 6'h23;
  localparam logic [5:0] FN_AND    = 6'h24;
  localparam logic [5:0] FN_OR     = 6'h25;
  localparam logic [5:0] FN_XOR    = 6'h26;
  localparam logic [5:0] FN_NOR    = 6'h27;
  localparam logic [5:0] FN_SLT    = 6'h2a;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;
  localparam logic [4:0] REG_RA    = 5'd31;
  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam logic [1:0] TNEW_NONE = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;
  function automatic logic hazard(input logic [4:0] src, input logic [1:0] tuse,
                                  input logic [4:0] dst, input logic [1:0] tnew);
    return src != 5'd0 && src == dst && tuse < tnew;
  endfunction
endpackage

// File: rtl/issue_reg_de_tuse_tnew_dec.sv
// tuse_tnew_dec: classifies a D-stage instruction into operand use times, result ready time and write register
module tuse_tnew_dec
  import mips_defs::*;
(
  input  logic [5:0] op,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  input  logic [5:0] fn,
  output logic [1:0] tuse_rs,
  output logic [1:0] tuse_rt,
  output logic [1:0] tnew,
  output logic [4:0] dst
);
  logic rtype, r_alu, r_shamt, jr, jalr, link_b, br, i_alu, lui, load, store, jal;
  always_comb begin
    rtype   = op == OP_RTYPE;
    r_alu   = rtype && fn inside {FN_ADDU, FN_ADD, FN_SUBU, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR,
                                  FN_SLT, FN_SLL, FN_SLLV, FN_SRL, FN_SRLV, FN_SRA, FN_MOVZ};
    r_shamt = rtype && fn inside {FN_SLL, FN_SRL, FN_SRA};
    jr      = rtype && fn == FN_JR;
    jalr    = rtype && fn == FN_JALR;
    link_b  = op == OP_REGIMM && rt inside {RT_BLTZAL, RT_BGEZAL};
    br      = op inside {OP_BEQ, OP_BNE};
    i_alu   = op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU};
    lui     = op == OP_LUI;
    load    = op inside {OP_LW, OP_LB};
    store   = op inside {OP_SW, OP_SB};
    jal     = op == OP_JAL;
    tuse_rs = (jr || jalr || link_b || br) ? 2'd0 :
              ((r_alu && !r_shamt) || i_alu || load || store) ? 2'd1 : TUSE_NONE;
    tuse_rt = br ? 2'd0 : r_alu ? 2'd1 : store ? 2'd2 : TUSE_NONE;
    tnew    = load ? TNEW_LOAD : (r_alu || i_alu || lui) ? TNEW_ALU : TNEW_NONE;
    dst     = (r_alu || jalr) ? rd : (i_alu || lui || load) ? rt : (jal || link_b) ? REG_RA : 5'd0;
  end
  logic unused_rs;
  assign unused_rs = ^rs;
endmodule

// File: rtl/issue_reg_de.sv
// issue_reg_de: D->E pipeline register with E/M hazard tracking and load-use stall/bubble injection
module issue_reg_de
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC8 = 32'h0000_3008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_D,
  input  logic [31:0] pc8_D,
  input  logic [31:0] rs_data_D,
  input  logic [31:0] rt_data_D,
  input  logic [31:0] ext_D,
  output logic [31:0] instr_E,
  output logic [31:0] pc8_E,
  output logic [31:0] rs_data_E,
  output logic [31:0] rt_data_E,
  output logic [31:0] ext_E,
  output logic [4:0]  dst_E,
  output logic [4:0]  dst_M,
  output logic        stall
);
  logic [1:0] tuse_rs, tuse_rt, tnew_D, tnew_E, tnew_M;
  logic [4:0] dst_D;
  logic       bub;
  tuse_tnew_dec u_dec (
    .op(instr_D[31:26]), .rs(instr_D[25:21]), .rt(instr_D[20:16]), .rd(instr_D[15:11]),
    .fn(instr_D[5:0]), .tuse_rs(tuse_rs), .tuse_rt(tuse_rt), .tnew(tnew_D), .dst(dst_D)
  );
  assign stall = hazard(instr_D[25:21], tuse_rs, dst_E, tnew_E) || hazard(instr_D[25:21], tuse_rs, dst_M, tnew_M) ||
                 hazard(instr_D[20:16], tuse_rt, dst_E, tnew_E) || hazard(instr_D[20:16], tuse_rt, dst_M, tnew_M);
  assign bub = reset || stall;
  always_ff @(posedge clk) begin
    instr_E   <= bub ? 32'd0 : instr_D;
    pc8_E     <= bub ? RESET_PC8 : pc8_D;
    rs_data_E <= bub ? 32'd0 : rs_data_D;
    rt_data_E <= bub ? 32'd0 : rt_data_D;
    ext_E     <= bub ? 32'd0 : ext_D;
    dst_E     <= bub ? 5'd0 : dst_D;
    tnew_E    <= bub ? TNEW_NONE : tnew_D;
    dst_M     <= reset ? 5'd0 : dst_E;
    tnew_M    <= (reset || tnew_E == TNEW_NONE) ? TNEW_NONE : tnew_E - 2'd1;
  end
endmodule

// File: tb/tb_issue_reg_de.sv
// tb_issue_reg_de: table-driven check of D->E register, hazard tracking and stall cycles
module tb_issue_reg_de;
  localparam logic [31:0] RESET_PC8 = 32'h0000_3008;
  localparam logic [31:0] LW8  = 32'h8D28_0000;
  localparam logic [31:0] LW9  = 32'h8D29_0000;
  localparam logic [31:0] LW0  = 32'h8D20_0000;
  localparam logic [31:0] ADDU = 32'h0108_5021;
  localparam logic [31:0] ADD0 = 32'h0000_5021;
  localparam logic [31:0] BGZL = 32'h0511_0004;
  localparam logic [31:0] SW   = 32'hAD28_0000;
  localparam logic [31:0] BEQ  = 32'h1140_0000;
  localparam logic [31:0] JAL  = 32'h0C00_0000;
  logic clk = 1'b0, reset;
  logic [31:0] instr_D, pc8_D, rs_data_D, rt_data_D, ext_D;
  logic [31:0] instr_E, pc8_E, rs_data_E, rt_data_E, ext_E;
  logic [4:0] dst_E, dst_M;
  logic stall;
  int passed = 0, total = 0;
  typedef struct packed {
    logic        rst;
    logic [31:0] instr;
    logic        stall;
    logic [31:0] ie;
    logic [4:0]  de;
    logic [4:0]  dm;
  } vec_t;
  vec_t vecs[$];
  issue_reg_de #(.RESET_PC8(RESET_PC8)) dut (
    .clk(clk), .reset(reset), .instr_D(instr_D), .pc8_D(pc8_D), .rs_data_D(rs_data_D),
    .rt_data_D(rt_data_D), .ext_D(ext_D), .instr_E(instr_E), .pc8_E(pc8_E), .rs_data_E(rs_data_E),
    .rt_data_E(rt_data_E), .ext_E(ext_E), .dst_E(dst_E), .dst_M(dst_M), .stall(stall)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
  endtask
  initial begin
    logic bub;
    int n;
    reset = 1'b1;
    instr_D = LW8;
    pc8_D = 0;
    rs_data_D = 0;
    rt_data_D = 0;
    ext_D = 0;
    vecs.push_back('{1'b1, LW8,  1'b0, 32'd0, 5'd0,  5'd0});
    vecs.push_back('{1'b1, LW8,  1'b0, 32'd0, 5'd0,  5'd0});
    vecs.push_back('{1'b0, LW8,  1'b0, LW8,   5'd8,  5'd0});
    vecs.push_back('{1'b0, ADDU, 1'b1, 32'd0, 5'd0,  5'd8});
    vecs.push_back('{1'b0, ADDU, 1'b0, ADDU,  5'd10, 5'd0});
    vecs.push_back('{1'b0, LW8,  1'b0, LW8,   5'd8,  5'd10});
    vecs.push_back('{1'b0, BGZL, 1'b1, 32'd0, 5'd0,  5'd8});
    vecs.push_back('{1'b0, BGZL, 1'b1, 32'd0, 5'd0,  5'd0});
    vecs.push_back('{1'b0, BGZL, 1'b0, BGZL,  5'd31, 5'd0});
    vecs.push_back('{1'b0, LW8,  1'b0, LW8,   5'd8,  5'd31});
    vecs.push_back('{1'b0, SW,   1'b0, SW,    5'd0,  5'd8});
    vecs.push_back('{1'b0, LW9,  1'b0, LW9,   5'd9,  5'd0});
    vecs.push_back('{1'b0, SW,   1'b1, 32'd0, 5'd0,  5'd9});
    vecs.push_back('{1'b0, SW,   1'b0, SW,    5'd0,  5'd0});
    vecs.push_back('{1'b0, ADDU, 1'b0, ADDU,  5'd10, 5'd0});
    vecs.push_back('{1'b0, BEQ,  1'b1, 32'd0, 5'd0,  5'd10});
    vecs.push_back('{1'b0, BEQ,  1'b0, BEQ,   5'd0,  5'd0});
    vecs.push_back('{1'b0, LW0,  1'b0, LW0,   5'd0,  5'd0});
    vecs.push_back('{1'b0, ADD0, 1'b0, ADD0,  5'd10, 5'd0});
    vecs.push_back('{1'b0, LW8,  1'b0, LW8,   5'd8,  5'd10});
    vecs.push_back('{1'b0, BGZL, 1'b1, 32'd0, 5'd0,  5'd8});
    vecs.push_back('{1'b1, BGZL, 1'b1, 32'd0, 5'd0,  5'd0});
    vecs.push_back('{1'b0, ADD0, 1'b0, ADD0,  5'd10, 5'd0});
    vecs.push_back('{1'b0, JAL,  1'b0, JAL,   5'd31, 5'd10});
    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst;
      instr_D = vecs[i].instr;
      pc8_D = 32'h0000_4000 + 32'(i) * 4;
      rs_data_D = 32'h1000_0000 | 32'(i);
      rt_data_D = 32'h2000_0000 | 32'(i);
      ext_D = 32'h3000_0000 | 32'(i);
      #1;
      if (i > 0) chk("stall", i, {31'd0, stall}, {31'd0, vecs[i].stall});
      bub = vecs[i].rst || vecs[i].stall;
      @(posedge clk);
      #1;
      chk("instr_E", i, instr_E, vecs[i].ie);
      chk("dst_E", i, {27'd0, dst_E}, {27'd0, vecs[i].de});
      chk("dst_M", i, {27'd0, dst_M}, {27'd0, vecs[i].dm});
      chk("pc8_E", i, pc8_E, bub ? RESET_PC8 : 32'h0000_4000 + 32'(i) * 4);
      chk("rs_data_E", i, rs_data_E, bub ? 32'd0 : 32'h1000_0000 | 32'(i));
      chk("rt_data_E", i, rt_data_E, bub ? 32'd0 : 32'h2000_0000 | 32'(i));
      chk("ext_E", i, ext_E, bub ? 32'd0 : 32'h3000_0000 | 32'(i));
    end
    @(negedge clk);
    reset = 1'b0;
    instr_D = LW8;
    @(negedge clk);
    instr_D = BGZL;
    #1;
    n = 0;
    for (int k = 0; k < 6 && stall; k++) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("lw_bgezal_stall_cycles", 100, 32'(n), 32'd2);
    @(posedge clk);
    #1;
    chk("bgezal_issue", 100, instr_E, BGZL);
    chk("bgezal_dst", 100, {27'd0, dst_E}, 32'd31);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
